// File: rtl/parking_lane_arbiter_if.sv
// Lane-side and lot-controller-side signals of the parking lane arbiter.
// master = arbiter, slave = lane keypads/sensors plus lot controller.
interface parking_lane_arbiter_if #(
  parameter int NUM_LANES = 4
);
  // Handshake: a lane holds lane_req high until its one-cycle lane_done pulse; lane_ok
  // is meaningful only alongside lane_done. enter_req/exit_req are one-cycle requests to
  // the lot controller, answered by a gate pulse inside the response window.
  logic [NUM_LANES-1:0]   lane_req;
  logic [NUM_LANES-1:0]   lane_dir;
  logic [8*NUM_LANES-1:0] lane_passcode;
  logic                   entry_gate_open;
  logic                   exit_gate_open;
  logic                   enter_req;
  logic                   exit_req;
  logic [7:0]             passcode_out;
  logic [NUM_LANES-1:0]   lane_grant;
  logic [NUM_LANES-1:0]   lane_done;
  logic [NUM_LANES-1:0]   lane_ok;
  logic                   busy;
  logic [7:0]             reject_count;

  modport master (
    input  lane_req, lane_dir, lane_passcode, entry_gate_open, exit_gate_open,
    output enter_req, exit_req, passcode_out, lane_grant, lane_done, lane_ok,
           busy, reject_count
  );

  modport slave (
    output lane_req, lane_dir, lane_passcode, entry_gate_open, exit_gate_open,
    input  enter_req, exit_req, passcode_out, lane_grant, lane_done, lane_ok,
           busy, reject_count
  );
endinterface

// File: rtl/parking_lane_arbiter.sv
// Round-robin arbiter sharing one lot controller among NUM_LANES lanes.
// Optional PARKING_ARB_EXIT_PRIORITY_EN: exit requesters win over entry requesters.
module parking_lane_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int RESP_WAIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  parking_lane_arbiter_if.master        bus,
  output logic [1:0]                    o_dbg_state
);
  localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t               r_state;
  logic [IW-1:0]        r_rr_ptr;
  logic [IW-1:0]        r_idx;
  logic                 r_dir;
  logic                 r_ok_flag;
  logic                 r_settle;
  logic [3:0]           r_timer;
  logic                 r_enter_req;
  logic                 r_exit_req;
  logic [7:0]           r_passcode;
  logic [NUM_LANES-1:0] r_grant;
  logic [NUM_LANES-1:0] r_done;
  logic [NUM_LANES-1:0] r_ok;
  logic                 r_busy;
  logic [7:0]           r_reject_count;

  logic [NUM_LANES-1:0] w_cand;
  logic [IW-1:0]        w_win_idx;
  logic                 w_win_valid;
  logic [NUM_LANES-1:0] w_win_onehot;
  logic                 w_gate_match;
  logic [3:0]           w_timer_inc;

  always_comb begin
`ifdef PARKING_ARB_EXIT_PRIORITY_EN
    w_cand = (|(bus.lane_req & bus.lane_dir)) ? (bus.lane_req & bus.lane_dir) : bus.lane_req;
`else
    w_cand = bus.lane_req;
`endif
  end

  // First set candidate at or after r_rr_ptr, wrapping at NUM_LANES.
  always_comb begin
    logic [IW:0] v_pos;
    v_pos       = '0;
    w_win_idx   = '0;
    w_win_valid = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      v_pos = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (v_pos >= (IW+1)'(NUM_LANES)) v_pos = v_pos - (IW+1)'(NUM_LANES);
      if (!w_win_valid && w_cand[v_pos[IW-1:0]]) begin
        w_win_valid = 1'b1;
        w_win_idx   = v_pos[IW-1:0];
      end
    end
  end

  assign w_win_onehot = {{(NUM_LANES-1){1'b0}}, 1'b1} << w_win_idx;
  assign w_gate_match = r_dir ? bus.exit_gate_open : bus.entry_gate_open;
  assign w_timer_inc  = r_timer + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_idx          <= '0;
      r_dir          <= 1'b0;
      r_ok_flag      <= 1'b0;
      r_settle       <= 1'b0;
      r_timer        <= '0;
      r_enter_req    <= 1'b0;
      r_exit_req     <= 1'b0;
      r_passcode     <= '0;
      r_grant        <= '0;
      r_done         <= '0;
      r_ok           <= '0;
      r_busy         <= 1'b0;
      r_reject_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // The first IDLE cycle after DONE gives the finished lane time to drop
          // its request, so a stale request is never granted again.
          if (r_settle) begin
            r_settle <= 1'b0;
          end else if (w_win_valid) begin
            r_state     <= S_ISSUE;
            r_idx       <= w_win_idx;
            r_dir       <= bus.lane_dir[w_win_idx];
            r_ok_flag   <= 1'b0;
            r_passcode  <= bus.lane_passcode[8*w_win_idx +: 8];
            r_grant     <= w_win_onehot;
            r_enter_req <= ~bus.lane_dir[w_win_idx];
            r_exit_req  <= bus.lane_dir[w_win_idx];
            r_busy      <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_enter_req <= 1'b0;
          r_exit_req  <= 1'b0;
          r_timer     <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= w_timer_inc;
          if (w_gate_match) r_ok_flag <= 1'b1;
          if (w_timer_inc == 4'(RESP_WAIT)) begin
            r_state <= S_DONE;
            r_done  <= r_grant;
            r_ok    <= (r_ok_flag || w_gate_match) ? r_grant : '0;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_settle   <= 1'b1;
          r_done     <= '0;
          r_ok       <= '0;
          r_grant    <= '0;
          r_passcode <= '0;
          r_busy     <= 1'b0;
          r_rr_ptr   <= (r_idx == IW'(NUM_LANES-1)) ? '0 : r_idx + 1'b1;
          if (!r_ok_flag && r_reject_count != 8'hFF) r_reject_count <= r_reject_count + 8'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.enter_req    = r_enter_req;
  assign bus.exit_req     = r_exit_req;
  assign bus.passcode_out = r_passcode;
  assign bus.lane_grant   = r_grant;
  assign bus.lane_done    = r_done;
  assign bus.lane_ok      = r_ok;
  assign bus.busy         = r_busy;
  assign bus.reject_count = r_reject_count;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Directed bench for parking_lane_arbiter: vector table plus multi-cycle sequences.
// Exit-priority expectations follow PARKING_ARB_EXIT_PRIORITY_EN when defined.
module tb_parking_lane_arbiter;
  localparam int NL = 4;
  localparam int RW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         n_total = 0;
  int         n_bad   = 0;

  parking_lane_arbiter_if #(.NUM_LANES(NL)) bus ();

  parking_lane_arbiter #(.NUM_LANES(NL), .RESP_WAIT(RW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lane;
    bit         dir;
    logic [7:0] code;
    int         gate;     // 0 none, 1 entry pulse, 2 exit pulse, 3 both
    bit         exp_ok;
    int         exp_rej;
  } vec_t;

  vec_t vecs[6];
  logic [NL-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_enter"},  32'(bus.enter_req),    0);
    check({tag, "_exit"},   32'(bus.exit_req),     0);
    check({tag, "_pass"},   32'(bus.passcode_out), 0);
    check({tag, "_grant"},  32'(bus.lane_grant),   0);
    check({tag, "_done"},   32'(bus.lane_done),    0);
    check({tag, "_ok"},     32'(bus.lane_ok),      0);
    check({tag, "_busy"},   32'(bus.busy),         0);
    check({tag, "_rej"},    32'(bus.reject_count), 0);
    check({tag, "_state"},  32'(dbg_state),        0);
  endtask

  task automatic do_reset();
    reset                = 1'b1;
    bus.lane_req         = '0;
    bus.lane_dir         = '0;
    bus.lane_passcode    = '0;
    bus.entry_gate_open  = 1'b0;
    bus.exit_gate_open   = 1'b0;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;
    tick();
  endtask

  // Single-lane transaction; the lot controller model pulses the chosen gate(s) at cycle 3.
  task automatic run_txn(input int lane, input bit dir, input logic [7:0] code,
                         input int gate, input bit exp_ok, input int exp_rej);
    bus.lane_passcode                = '0;
    bus.lane_passcode[8*lane +: 8]   = code;
    bus.lane_dir                     = '0;
    bus.lane_dir[lane]               = dir;
    bus.lane_req                     = '0;
    bus.lane_req[lane]               = 1'b1;
    for (int c = 1; c <= RW + 4; c++) begin
      tick();
      if (c == 3) begin
        bus.entry_gate_open = (gate == 1 || gate == 3);
        bus.exit_gate_open  = (gate == 2 || gate == 3);
      end else begin
        bus.entry_gate_open = 1'b0;
        bus.exit_gate_open  = 1'b0;
      end
      if (c == 1) begin
        check("issue_enter", 32'(bus.enter_req), 32'(!dir));
        check("issue_exit",  32'(bus.exit_req),  32'(dir));
        check("issue_grant", 32'(bus.lane_grant), 32'(1 << lane));
        check("issue_pass",  32'(bus.passcode_out), 32'(code));
        check("issue_busy",  32'(bus.busy), 1);
      end
      if (c == 2) check("wait_req_low", 32'(bus.enter_req | bus.exit_req), 0);
      if (c == RW + 1) check("wait_no_done", 32'(bus.lane_done), 0);
      if (c == RW + 2) begin
        check("done_pulse", 32'(bus.lane_done), 32'(1 << lane));
        check("done_ok",    32'(bus.lane_ok),   32'(exp_ok ? (1 << lane) : 0));
        check("done_pass",  32'(bus.passcode_out), 32'(code));
        bus.lane_req = '0;
      end
      if (c == RW + 3) begin
        check("idle_done",  32'(bus.lane_done), 0);
        check("idle_busy",  32'(bus.busy), 0);
        check("idle_pass",  32'(bus.passcode_out), 0);
        check("idle_grant", 32'(bus.lane_grant), 0);
        check("idle_rej",   32'(bus.reject_count), 32'(exp_rej));
      end
    end
  endtask

  initial begin
    int n_iss;
    int l0_dones;
    vecs[0] = '{lane: 0, dir: 1'b0, code: 8'hFF, gate: 1, exp_ok: 1'b1, exp_rej: 0};
    vecs[1] = '{lane: 2, dir: 1'b0, code: 8'h12, gate: 0, exp_ok: 1'b0, exp_rej: 1};
    vecs[2] = '{lane: 1, dir: 1'b1, code: 8'h5A, gate: 1, exp_ok: 1'b0, exp_rej: 2};
    vecs[3] = '{lane: 3, dir: 1'b1, code: 8'hA5, gate: 2, exp_ok: 1'b1, exp_rej: 2};
    vecs[4] = '{lane: 1, dir: 1'b0, code: 8'h00, gate: 2, exp_ok: 1'b0, exp_rej: 3};
    vecs[5] = '{lane: 2, dir: 1'b1, code: 8'h3C, gate: 3, exp_ok: 1'b1, exp_rej: 3};

    do_reset();
    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].lane, vecs[i].dir, vecs[i].code, vecs[i].gate, vecs[i].exp_ok, vecs[i].exp_rej);

    // Round-robin among lanes 0,1,3; lane 0 keeps requesting after its first DONE.
    do_reset();
    exp_q = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    n_iss    = 0;
    l0_dones = 0;
    bus.lane_dir = '0;
    bus.lane_req = 4'b1011;
    for (int c = 1; c <= 31; c++) begin
      tick();
      if (bus.enter_req) begin
        check("rr_issue_cycle", 32'(c), 32'(1 + 8 * n_iss));
        if (exp_q.size() > 0) check("rr_grant", 32'(bus.lane_grant), 32'(exp_q.pop_front()));
        else check("rr_extra_grant", 32'(bus.lane_grant), 0);
        n_iss++;
      end
      if (bus.lane_done[0]) begin
        l0_dones++;
        if (l0_dones == 2) bus.lane_req[0] = 1'b0;
      end
      if (bus.lane_done[1]) bus.lane_req[1] = 1'b0;
      if (bus.lane_done[3]) bus.lane_req[3] = 1'b0;
    end
    check("rr_issue_count", 32'(n_iss), 4);
    check("rr_rej", 32'(bus.reject_count), 4);
    tick();

    // Reset during WAIT: lane 2 is in flight, no done may follow.
    bus.lane_req = 4'b0100;
    tick();
    check("mid_grant", 32'(bus.lane_grant), 32'b0100);
    tick();
    tick();
    check("mid_state_wait", 32'(dbg_state), 2);
    reset = 1'b1;
    #1;
    check_zero("async_rst");
    bus.lane_req = '0;
    tick();
    check("rst_no_done", 32'(bus.lane_done), 0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("post_rst_no_done", 32'(bus.lane_done), 0);
    end
    bus.lane_req = 4'b0101;
    tick();
    check("post_rst_grant", 32'(bus.lane_grant), 32'b0001);
    check("post_rst_enter", 32'(bus.enter_req), 1);
    for (int c = 2; c <= RW + 2; c++) tick();
    check("post_rst_done", 32'(bus.lane_done), 32'b0001);
    bus.lane_req = '0;
    tick();
    tick();

    // Simultaneous entry (lane 0) and exit (lane 3) with rr_ptr at 0.
    do_reset();
    bus.lane_dir = 4'b1000;
    bus.lane_passcode = 32'h44000011;
    bus.lane_req = 4'b1001;
    tick();
`ifdef PARKING_ARB_EXIT_PRIORITY_EN
    check("prio_grant", 32'(bus.lane_grant), 32'b1000);
    check("prio_exit",  32'(bus.exit_req), 1);
    check("prio_pass",  32'(bus.passcode_out), 32'h44);
`else
    check("prio_grant", 32'(bus.lane_grant), 32'b0001);
    check("prio_enter", 32'(bus.enter_req), 1);
    check("prio_pass",  32'(bus.passcode_out), 32'h11);
`endif
    for (int c = 2; c <= RW + 2; c++) tick();
    check("prio_done_any", 32'(|bus.lane_done), 1);
    bus.lane_req = '0;
    tick();
    tick();

    // Saturating reject counter.
    do_reset();
    for (int i = 0; i < 260; i++)
      run_txn(i % NL, 1'b0, 8'(i), 0, 1'b0, (i + 1 > 255) ? 255 : i + 1);
    check("sat_final", 32'(bus.reject_count), 255);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
